// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-memory responder: OBI address/data words,
// the response pipeline entry and the grant FSM state encoding.
package instr_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] obi_addr_t;
    typedef logic [31:0] obi_data_t;

    typedef struct packed {
        logic      valid;
        obi_data_t data;
    } rsp_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } gnt_state_e;

endpackage

// File: rtl/instr_mem_responder_rsp_pipe.sv
// Fixed-latency response pipeline. Each stage carries a valid bit and a data
// word. A stage only takes new data when the incoming entry is valid, so the
// last stage holds the most recent response word while no response is due.
module instr_rsp_pipe
    import instr_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  rsp_entry_t in_entry,
    output logic       rvalid,
    output obi_data_t  rdata
);

    rsp_entry_t stage_p [LATENCY];

    // Shift responses one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_p[i].valid <= 1'b0;
                stage_p[i].data  <= '0;
            end
        end else begin
            stage_p[0].valid <= in_entry.valid;
            if (in_entry.valid) begin
                stage_p[0].data <= in_entry.data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_p[i].valid <= stage_p[i-1].valid;
                if (stage_p[i-1].valid) begin
                    stage_p[i].data <= stage_p[i-1].data;
                end
            end
        end
    end

    assign rvalid = stage_p[LATENCY-1].valid;
    assign rdata  = stage_p[LATENCY-1].data;

endmodule

// File: rtl/instr_mem_responder.sv
// Memory end of the instruction fetch interface. Requests are granted after a
// programmable stall, bounded by an outstanding-transaction limit, and answered
// in order after a fixed latency. A backdoor port preloads program images.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int        MEM_DEPTH_WORDS = 1024,
    parameter obi_addr_t BASE_ADDR       = 32'h0000_0000,
    parameter int        RVALID_LATENCY  = 1,
    parameter int        MAX_OUTSTANDING = 2,
    parameter obi_data_t OOB_WORD        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic [3:0]  gnt_stall_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i,
    output logic [2:0]  outstanding_o,
    output logic        oob_o
);

    localparam int IDX_W      = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    // True when a byte address maps onto a word of the array.
    function automatic logic in_range(input obi_addr_t addr);
        obi_addr_t word_off;
        word_off = (addr - BASE_ADDR) >> WORD_SHIFT;
        return (addr >= BASE_ADDR) && (word_off < obi_addr_t'(MEM_DEPTH_WORDS));
    endfunction

    // Word index of an in-range byte address.
    function automatic logic [IDX_W-1:0] word_index(input obi_addr_t addr);
        obi_addr_t word_off;
        word_off = (addr - BASE_ADDR) >> WORD_SHIFT;
        return IDX_W'(word_off);
    endfunction

    obi_data_t   mem [MEM_DEPTH_WORDS];

    gnt_state_e  state;
    gnt_state_e  state_next;
    logic [3:0]  stall_cnt;
    logic [3:0]  stall_cnt_next;
    logic        gnt_eligible;
    logic        gnt;
    logic [2:0]  outstanding;
    logic        oob;
    rsp_entry_t  rsp_in;
    logic        rsp_valid;
    obi_data_t   rsp_data;

    // FSM state and stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    // Next-state logic. The IDLE cycle that first sees the request counts as
    // the first stall cycle, so a stall of N grants on the (N+1)th request
    // cycle; the counter therefore starts at N-1.
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        case (state)
            IDLE: begin
                if (instr_req_i) begin
                    if (gnt_stall_i == 4'd1) begin
                        state_next = READY;
                    end else if (gnt_stall_i != 4'd0) begin
                        state_next     = WAIT;
                        stall_cnt_next = gnt_stall_i - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!instr_req_i) begin
                    state_next     = IDLE;
                    stall_cnt_next = '0;
                end else begin
                    stall_cnt_next = stall_cnt - 4'd1;
                    if (stall_cnt == 4'd1) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (!instr_req_i || gnt) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                stall_cnt_next = '0;
            end
        endcase
    end

    // Grant output: eligible state, request present, below the outstanding limit.
    always_comb begin
        gnt_eligible = 1'b0;
        case (state)
            IDLE:    gnt_eligible = (gnt_stall_i == 4'd0);
            READY:   gnt_eligible = 1'b1;
            default: gnt_eligible = 1'b0;
        endcase
        gnt = instr_req_i && gnt_eligible && rst_n &&
              (outstanding < 3'(MAX_OUTSTANDING));
    end

    // Outstanding count: up on grant, down when a response is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({gnt, rsp_valid})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   if (outstanding != 3'd0) outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oob <= 1'b0;
        end else if (gnt && !in_range(instr_addr_i)) begin
            oob <= 1'b1;
        end
    end

    // Backdoor load; array contents survive reset and stray loads are ignored.
    always_ff @(posedge clk) begin
        if (load_we_i && in_range(load_addr_i)) begin
            mem[word_index(load_addr_i)] <= load_wdata_i;
        end
    end

    // Read in the grant cycle; the pipeline captures the pre-write word.
    always_comb begin
        rsp_in.valid = gnt;
        rsp_in.data  = OOB_WORD;
        if (in_range(instr_addr_i)) begin
            rsp_in.data = mem[word_index(instr_addr_i)];
        end
    end

    instr_rsp_pipe #(
        .LATENCY (RVALID_LATENCY)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_entry (rsp_in),
        .rvalid   (rsp_valid),
        .rdata    (rsp_data)
    );

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rsp_valid;
    assign instr_rdata_o  = rsp_data;
    assign outstanding_o  = outstanding;
    assign oob_o          = oob;

endmodule
